// File: rtl/sizes_pkg.sv
// Shared keypad sizes, FSM state type and key-code table for control_lectura.
package sizes_pkg;

  localparam int KEYPAD_ROWS    = 4;
  localparam int KEYPAD_COLS    = 4;
  localparam int KEY_CODE_WIDTH = 4;

  localparam logic [KEY_CODE_WIDTH-1:0] KEY_STAR = 4'hE;
  localparam logic [KEY_CODE_WIDTH-1:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  // Physical layout: r0 1 2 3 A / r1 4 5 6 B / r2 7 8 9 C / r3 * 0 # D
  function automatic logic [KEY_CODE_WIDTH-1:0] key_code(input logic [1:0] row,
                                                         input logic [1:0] col);
    logic [KEY_CODE_WIDTH-1:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_HASH;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/control_lectura.sv
// 4x4 keypad scanner with debounce, one-entry key buffer (valid/ready) and
// optional BCD accumulator enabled by defining KEY_ACCUM_EN.
module control_lectura
  import sizes_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [KEYPAD_ROWS-1:0]      row_n_i,
  output logic [KEYPAD_COLS-1:0]      col_n_o,
  output logic [KEY_CODE_WIDTH-1:0]   key_code_o,
  output logic                        key_valid_o,
  input  logic                        key_ready_i,
  output logic                        key_drop_o,
  output logic [4*NUM_DIGITS-1:0]     acc_o
);

  localparam int ACC_W = 4 * NUM_DIGITS;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  // Handshake: key_code_o is held while key_valid_o is high; a key is consumed
  // on every rising edge where key_valid_o and key_ready_i are both high.

  logic [KEYPAD_ROWS-1:0]    w_rows;
  logic                      w_rows_idle;
  logic [1:0]                w_low_row;
  logic                      w_confirm;
  logic                      w_load;
  logic [KEY_CODE_WIDTH-1:0] w_code;

  state_t                    r_state;
  logic [1:0]                r_col;
  logic [DIV_W-1:0]          r_div;
  logic [DEB_W-1:0]          r_deb;
  logic [1:0]                r_row;
  logic [KEYPAD_ROWS-1:0]    r_pattern;
  logic                      r_valid;
  logic [KEY_CODE_WIDTH-1:0] r_code;
  logic                      r_drop;

  // Rows reset to idle-high so nothing looks pressed coming out of reset.
  sync_2ff #(
    .WIDTH     (KEYPAD_ROWS),
    .RESET_VAL ({KEYPAD_ROWS{1'b1}})
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (row_n_i),
    .q_o   (w_rows)
  );

  assign w_rows_idle = &w_rows;

  always_comb begin
    w_low_row = 2'd0;
    for (int i = KEYPAD_ROWS - 1; i >= 0; i--) begin
      if (!w_rows[i]) w_low_row = 2'(i);
    end
  end

  assign w_code    = key_code(r_row, r_col);
  assign w_confirm = (r_state == ST_DEBOUNCE) && (w_rows == r_pattern) && (r_deb == DEB_LAST);
  assign w_load    = w_confirm && (!r_valid || key_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_SCAN;
      r_col     <= 2'd0;
      r_div     <= '0;
      r_deb     <= '0;
      r_row     <= 2'd0;
      r_pattern <= {KEYPAD_ROWS{1'b1}};
    end else begin
      case (r_state)
        ST_SCAN: begin
          if (!w_rows_idle) begin
            r_state   <= ST_DEBOUNCE;
            r_row     <= w_low_row;
            r_pattern <= w_rows;
            r_deb     <= '0;
          end else if (r_div == DIV_LAST) begin
            r_div <= '0;
            r_col <= r_col + 2'd1;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          // Bounce sends us back to scanning from the frozen column.
          if (w_rows != r_pattern) begin
            r_state <= ST_SCAN;
            r_div   <= '0;
          end else if (r_deb == DEB_LAST) begin
            r_state <= ST_HELD;
          end else begin
            r_deb <= r_deb + DEB_W'(1);
          end
        end
        ST_HELD: begin
          if (w_rows_idle) begin
            r_state <= ST_RELEASE;
            r_deb   <= '0;
          end
        end
        ST_RELEASE: begin
          if (!w_rows_idle) begin
            r_state <= ST_HELD;
          end else if (r_deb == DEB_LAST) begin
            r_state <= ST_SCAN;
            r_div   <= '0;
          end else begin
            r_deb <= r_deb + DEB_W'(1);
          end
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (w_load) begin
        r_valid <= 1'b1;
        r_code  <= w_code;
      end else if (w_confirm) begin
        r_drop <= 1'b1;
      end else if (key_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef KEY_ACCUM_EN
  logic [ACC_W-1:0] r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_load) begin
      if (w_code <= 4'h9) begin
        r_acc <= ACC_W'({r_acc, w_code});
      end else if (w_code == KEY_STAR) begin
        r_acc <= '0;
      end
    end
  end

  assign acc_o = r_acc;
`else
  assign acc_o = {ACC_W{1'b0}};
`endif

  assign col_n_o     = ~(4'b0001 << r_col);
  assign key_code_o  = r_code;
  assign key_valid_o = r_valid;
  assign key_drop_o  = r_drop;

endmodule

// File: doc/control_lectura.md
CONTROL_LECTURA -- requirements
Module: control_lectura

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles each column stays driven while scanning (>=2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 20000, meaning consecutive stable cycles required to confirm a press or release (>=1).
REQ-003 SHALL have parameter NUM_DIGITS, default 4, meaning BCD digits held in the accumulator (>=1).
REQ-004 SHALL have port: clk  input  1  system clock, all logic rising-edge.
REQ-005 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: row_n_i  input  4  keypad rows, active-low, asynchronous to clk.
REQ-007 SHALL have port: col_n_o  output  4  keypad column drive, active-low, one-hot-low.
REQ-008 SHALL have port: key_code_o  output  4  code of the buffered key.
REQ-009 SHALL have port: key_valid_o  output  1  buffered key available.
REQ-010 SHALL have port: key_ready_i  input  1  consumer accepts the key.
REQ-011 SHALL have port: key_drop_o  output  1  one-cycle pulse when a confirmed key is lost.
REQ-012 SHALL have port: acc_o  output  4*NUM_DIGITS  BCD accumulator, digit 0 in bits [3:0].

Function
REQ-013 SHALL pass row_n_i through a 2-flop synchronizer before any use; all row timing is measured at the synchronizer output.
REQ-014 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: SHALL drive exactly one column low and advance col0->col1->col2->col3->col0 every SCAN_DIV cycles.
REQ-016 SCAN: any synchronized row low SHALL freeze the column, latch the lowest-index low row and the column, clear the debounce counter, go to DEBOUNCE.
REQ-017 DEBOUNCE: synchronized row pattern differing from the latched one SHALL return to SCAN, resuming rotation from the frozen column with a fresh SCAN_DIV period.
REQ-018 DEBOUNCE: pattern stable for DEBOUNCE_CYCLES consecutive cycles SHALL confirm the key and go to HELD in the next cycle.
REQ-019 Key codes SHALL map (row,col): r0 1,2,3,A; r1 4,5,6,B; r2 7,8,9,C; r3 *,0,#,D; digits -> 0x0-0x9, A-D -> 0xA-0xD, * -> 0xE, # -> 0xF.
REQ-020 On confirmation, if key_valid_o is low or key_ready_i is high that cycle, the code SHALL load the one-entry buffer and key_valid_o SHALL be high the following cycle.
REQ-021 On confirmation with key_valid_o high and key_ready_i low, the new key SHALL be discarded, the buffer unchanged and key_drop_o pulsed one cycle.
REQ-022 key_valid_o and key_code_o SHALL stay stable until the cycle key_ready_i is sampled high; key_valid_o SHALL then fall unless a simultaneous load occurs (REQ-020).
REQ-023 HELD: all synchronized rows high SHALL go to RELEASE with counter cleared; column stays frozen; no repeat keys generated.
REQ-024 RELEASE: any row low SHALL return to HELD; all rows high for DEBOUNCE_CYCLES SHALL go to SCAN.

Reset
REQ-025 rst_n low SHALL immediately force: state SCAN, col_n_o 4'b1110, key_valid_o 0, key_code_o 0, key_drop_o 0, acc_o 0, counters and synchronizer 0 -> rows idle high.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL discard the pending key; no key_valid_o after release of reset until a new full press.

Configuration
REQ-027 With KEY_ACCUM_EN defined, each key loaded into the buffer SHALL update acc_o in the same cycle: 0x0-0x9 shifts acc_o left 4 bits inserting the digit at [3:0] (oldest digit lost); 0xE clears acc_o; other codes leave it; dropped keys do not affect it.
REQ-028 Without KEY_ACCUM_EN, acc_o SHALL be constant 0 and no accumulator registers SHALL exist.

Structure
REQ-029 sizes_pkg SHALL hold KEYPAD_ROWS=4, KEYPAD_COLS=4, KEY_CODE_WIDTH=4, the FSM state enum typedef and the 0xE/0xF special-key constants.
REQ-030 The row synchronizer SHALL be a sub-module named sync_2ff, parameterized by width.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8, NUM_DIGITS=4)
REQ-031 Reset -> col_n_o 1110, rotates 1101,1011,0111,1110 every 4 cycles; key_valid_o 0.
REQ-032 Row1 low while col2 driven, held 30 cycles, key_ready_i 1 -> one key_valid_o with code 0x6; no repeat while held.
REQ-033 Row0 low for 5 cycles only -> return to SCAN, no key_valid_o.
REQ-034 Press 5, key_ready_i 0, release, press 9 -> key_code_o stays 0x5, key_drop_o one pulse.
REQ-035 KEY_ACCUM_EN: keys 1,2,3,4,5 accepted -> acc_o 0x2345; then * -> 0x0000; then A -> 0x0000.
REQ-036 rst_n low during DEBOUNCE of key 8 -> col_n_o 1110, no key_valid_o after reset with rows high.
